// File: rtl/od_line_pkg.sv
// od_line_pkg: shared constants for the open-drain line controller.
//   MAX_CH             - largest supported channel count
//   DEF_DEB_CYCLES     - default debounce length (stable samples)
//   DEF_SYNC_STAGES    - default synchroniser depth
//   DEF_STRETCH_CYCLES - default minimum LED on-time (OD_STRETCH_EN builds)
//   LINE_IDLE          - level of an undriven line (external pull-up)
package od_line_pkg;
    localparam int   MAX_CH             = 16;
    localparam int   DEF_DEB_CYCLES     = 3855;
    localparam int   DEF_SYNC_STAGES    = 2;
    localparam int   DEF_STRETCH_CYCLES = 1000000;
    localparam logic LINE_IDLE          = 1'b1;
endpackage

// File: rtl/od_line_ctrl_if.sv
// od_line_ctrl_if: button inputs and per-channel status outputs of od_line_ctrl.
//   btn       - raw buttons, active-high (driven by master)
//   pressed   - debounced button level
//   press_p   - one-cycle pulse on debounced press
//   release_p - one-cycle pulse on debounced release
//   remote_p  - one-cycle pulse when a remote low is first detected
//   led       - 1 while the line is held low by a remote device
// Modports: master (board side / bench), slave (controller).
interface od_line_ctrl_if #(
    parameter int CH = 4
);
    logic [CH-1:0] btn;
    logic [CH-1:0] pressed;
    logic [CH-1:0] press_p;
    logic [CH-1:0] release_p;
    logic [CH-1:0] remote_p;
    logic [CH-1:0] led;

    modport master (
        output btn,
        input  pressed, press_p, release_p, remote_p, led
    );

    modport slave (
        input  btn,
        output pressed, press_p, release_p, remote_p, led
    );
endinterface

// File: rtl/od_debounce.sv
// od_debounce: single-channel button synchroniser and symmetric debouncer.
//   clk, rst      - clock, asynchronous active-low reset
//   btn_i         - raw asynchronous button
//   pressed_o     - debounced level (registered)
//   press_p_o     - one-cycle pulse on debounced 0->1 (registered)
//   release_p_o   - one-cycle pulse on debounced 1->0 (registered)
//   release_ev_o  - combinational: release is accepted at the coming edge;
//                   lets the caller start its guard on the same edge
module od_debounce #(
    parameter int DEB_CYCLES  = 3855,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic pressed_o,
    output logic press_p_o,
    output logic release_p_o,
    output logic release_ev_o
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   pressed_q;
    logic                   press_p_q;
    logic                   release_p_q;

    logic synced;
    logic differ;
    logic hit;

    assign synced = sync_q[SYNC_STAGES-1];
    assign differ = synced ^ pressed_q;
    // Count reaching DEB_CYCLES is never stored: the level flips instead.
    assign hit    = differ && (cnt_q == CW'(DEB_CYCLES - 1));

    assign release_ev_o = hit & pressed_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q      <= '0;
            cnt_q       <= '0;
            pressed_q   <= 1'b0;
            press_p_q   <= 1'b0;
            release_p_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], btn_i};
            press_p_q   <= hit & ~pressed_q;
            release_p_q <= hit & pressed_q;
            if (hit) begin
                pressed_q <= ~pressed_q;
                cnt_q     <= '0;
            end else if (differ) begin
                cnt_q <= cnt_q + CW'(1);
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign pressed_o   = pressed_q;
    assign press_p_o   = press_p_q;
    assign release_p_o = release_p_q;
endmodule

// File: rtl/od_line_ctrl.sv
// od_line_ctrl: multi-channel button to open-drain wired-AND line controller.
// Each channel debounces its button, pulls its line low while pressed and
// flags a low driven by another device on the line.
//   clk, rst - clock, asynchronous active-low reset
//   line     - open-drain lines (only ever driven low), external pull-up
//   bus      - od_line_ctrl_if.slave: btn in; pressed, press_p, release_p,
//              remote_p, led out
// Build option: OD_STRETCH_EN keeps led on for at least STRETCH_CYCLES
// after the remote low ends.
module od_line_ctrl
    import od_line_pkg::*;
#(
    parameter int CH             = 4,
    parameter int DEB_CYCLES     = DEF_DEB_CYCLES,
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int STRETCH_CYCLES = DEF_STRETCH_CYCLES
) (
    input  logic            clk,
    input  logic            rst,
    inout  wire  [CH-1:0]   line,
    od_line_ctrl_if.slave   bus
);
    localparam int              GW         = $clog2(SYNC_STAGES + 2);
    localparam logic [GW-1:0]   GUARD_LOAD = GW'(SYNC_STAGES + 1);

    logic [CH-1:0] pressed_w;
    logic [CH-1:0] rel_ev_w;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] ls_q;
        logic [GW-1:0]          guard_q;
        logic                   rl_q;
        logic                   rp_q;
        logic                   rl_d;
        logic                   led_w;

        od_debounce #(
            .DEB_CYCLES  (DEB_CYCLES),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_deb (
            .clk          (clk),
            .rst          (rst),
            .btn_i        (bus.btn[i]),
            .pressed_o    (pressed_w[i]),
            .press_p_o    (bus.press_p[i]),
            .release_p_o  (bus.release_p[i]),
            .release_ev_o (rel_ev_w[i])
        );

        // Own drive follows the async-reset pressed flop, so reset frees the line at once.
        assign line[i] = pressed_w[i] ? 1'b0 : 1'bz;

        // Own low is masked while driving, and by the guard while it drains
        // out of the synchroniser after release.
        assign rl_d = ~ls_q[SYNC_STAGES-1] & ~pressed_w[i] & (guard_q == '0);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                ls_q    <= {SYNC_STAGES{LINE_IDLE}};
                guard_q <= '0;
                rl_q    <= 1'b0;
                rp_q    <= 1'b0;
            end else begin
                ls_q <= {ls_q[SYNC_STAGES-2:0], line[i]};
                if (rel_ev_w[i]) begin
                    guard_q <= GUARD_LOAD;
                end else if (guard_q != '0) begin
                    guard_q <= guard_q - GW'(1);
                end
                rl_q <= rl_d;
                rp_q <= rl_d & ~rl_q;
            end
        end

`ifdef OD_STRETCH_EN
        localparam int SW = $clog2(STRETCH_CYCLES + 1);
        logic [SW-1:0] str_q;
        logic          led_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                str_q <= '0;
                led_q <= 1'b0;
            end else begin
                if (rl_d) begin
                    str_q <= SW'(STRETCH_CYCLES);
                end else if (str_q != '0) begin
                    str_q <= str_q - SW'(1);
                end
                led_q <= rl_d | (str_q != '0);
            end
        end

        assign led_w = led_q;
`else
        assign led_w = rl_q;
`endif

        assign bus.led[i]      = led_w;
        assign bus.remote_p[i] = rp_q;
    end

    assign bus.pressed = pressed_w;
endmodule

// File: tb/tb_od_line_ctrl.sv
module tb_od_line_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ext1 = 1'b0;

    always #5 clk = ~clk;

    od_line_ctrl_if #(.CH(2)) bus ();

    wire [1:0] line;
    pullup (line[0]);
    pullup (line[1]);
    assign line[1] = ext1 ? 1'b0 : 1'bz;

    od_line_ctrl #(
        .CH             (2),
        .DEB_CYCLES     (4),
        .SYNC_STAGES    (2),
        .STRETCH_CYCLES (8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .line (line),
        .bus  (bus)
    );

`ifdef OD_STRETCH_EN
    localparam logic STRETCH = 1'b1;
`else
    localparam logic STRETCH = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic [1:0] pp;
        logic [1:0] rp;
        logic [1:0] mp;
    } ev_t;

    ev_t  exp_q[$];
    ev_t  mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic led0_seen = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int c, input logic [1:0] pp, input logic [1:0] rp, input logic [1:0] mp);
        ev_t e;
        e.cyc = c; e.pp = pp; e.rp = rp; e.mp = mp;
        exp_q.push_back(e);
    endtask

    task automatic at(input int n);
        int budget;
        budget = 0;
        while (cyc != n) begin
            @(negedge clk);
            budget++;
            if (budget > 500) begin
                checks++;
                errors++;
                $display("FAIL timeout: waiting for cycle %0d, at %0d", n, cyc);
                return;
            end
        end
    endtask

    // Monitor: every output pulse must match the next expected event.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.led[0]) led0_seen = 1'b1;
            if (|{bus.press_p, bus.release_p, bus.remote_p}) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: cycle %0d press_p %b release_p %b remote_p %b, none required",
                             cyc, bus.press_p, bus.release_p, bus.remote_p);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.cyc != cyc || mon_e.pp !== bus.press_p ||
                        mon_e.rp !== bus.release_p || mon_e.mp !== bus.remote_p) begin
                        errors++;
                        $display("FAIL event: got cycle %0d p %b r %b m %b, required cycle %0d p %b r %b m %b",
                                 cyc, bus.press_p, bus.release_p, bus.remote_p,
                                 mon_e.cyc, mon_e.pp, mon_e.rp, mon_e.mp);
                    end
                end
            end
        end
    end

    initial begin
        bus.btn = 2'b00;
        repeat (3) @(negedge clk);
        chk("reset_pressed", 32'(bus.pressed), 32'h0);
        chk("reset_led", 32'(bus.led), 32'h0);
        chk("reset_pulses", 32'({bus.press_p, bus.release_p, bus.remote_p}), 32'h0);
        chk("reset_line", 32'(line), 32'h3);

        rst = 1'b1;

        // ch0 held; ch1 bounces 3 high, 1 low, 3 high, then low
        at(0);  bus.btn = 2'b11; push(6, 2'b01, 2'b00, 2'b00);
        at(3);  bus.btn[1] = 1'b0;
        at(4);  bus.btn[1] = 1'b1;
        at(7);  bus.btn[1] = 1'b0;
        chk("line0_driven", 32'(line[0]), 32'h0);
        chk("pressed_after_press", 32'(bus.pressed), 32'h1);

        at(10); ext1 = 1'b1; push(13, 2'b00, 2'b00, 2'b10);
        chk("bounce_no_press", 32'(bus.pressed), 32'h1);
        at(12); chk("led1_before", 32'(bus.led[1]), 32'h0);
        at(13); chk("led1_rise", 32'(bus.led[1]), 32'h1);
        at(21); ext1 = 1'b0;
        at(23); chk("led1_last", 32'(bus.led[1]), 32'h1);
        at(24); chk("led1_after", 32'(bus.led[1]), 32'(STRETCH));

        at(25); bus.btn[0] = 1'b0; push(31, 2'b00, 2'b01, 2'b00);
        at(31);
        chk("line0_released", 32'(line[0]), 32'h1);
        chk("pressed0_cleared", 32'(bus.pressed), 32'h0);
        if (STRETCH) chk("led1_stretch_end", 32'(bus.led[1]), 32'h1);
        at(32);
        if (STRETCH) chk("led1_stretch_off", 32'(bus.led[1]), 32'h0);

        at(40); bus.btn = 2'b11; push(46, 2'b11, 2'b00, 2'b00);
        at(47); chk("both_lines_low", 32'(line), 32'h0);
        at(50); bus.btn = 2'b00; push(56, 2'b00, 2'b11, 2'b00);
        at(57); chk("both_lines_free", 32'(line), 32'h3);
        at(59); chk("guard_led", 32'(bus.led), 32'h0);

        at(60); bus.btn = 2'b11; push(66, 2'b11, 2'b00, 2'b00);
        at(68); bus.btn[0] = 1'b0;
        at(72);
        #1 rst = 1'b0;
        #1;
        chk("midrst_pressed", 32'(bus.pressed), 32'h0);
        chk("midrst_line", 32'(line), 32'h3);
        chk("midrst_led", 32'(bus.led), 32'h0);
        chk("midrst_pulses", 32'({bus.press_p, bus.release_p, bus.remote_p}), 32'h0);

        bus.btn = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_pressed", 32'(bus.pressed), 32'h0);
        chk("post_line", 32'(line), 32'h3);

        chk("events_left", 32'(exp_q.size()), 32'h0);
        chk("led0_never", 32'(led0_seen), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/od_line_ctrl.md
# od_line_ctrl

Parametrised multi-channel button-to-open-drain-line controller. Each of CH channels debounces a push-button, pulls its shared bidirectional line low while the button is held, and detects when another device on the same line pulls it low. It sits between the board buttons and LEDs and the external wired-AND signal lines, and replaces per-design single-channel button/data pairs.

## Interface
- CH, 4, number of independent channels (1..16)
- DEB_CYCLES, 3855, consecutive stable samples required to accept a new button level (≥2)
- SYNC_STAGES, 2, synchroniser depth on button and line inputs (2..4)
- STRETCH_CYCLES, 1000000, minimum LED on-time when OD_STRETCH_EN is defined (≥1)

- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- btn  in  CH  raw button inputs, active-high, asynchronous
- line  inout  CH  open-drain lines; external pull-up; idle high
- led  out  CH  registered; 1 = line held low by a remote device
- pressed  out  CH  debounced button level
- press_p  out  CH  one-cycle pulse on debounced 0→1
- release_p  out  CH  one-cycle pulse on debounced 1→0
- remote_p  out  CH  one-cycle pulse on start of remote-low detection

## Operation
- Reset (rst=0): all counters 0, pressed=0, press_p/release_p/remote_p=0, led=0, button synchronisers 0, line synchronisers 1, guard counters 0; lines released (Z).
- Debounce per channel, symmetric: counter width $clog2(DEB_CYCLES+1). Synced btn ≠ pressed → counter+1; synced btn = pressed → counter cleared. When the increment would reach DEB_CYCLES: pressed toggles, counter clears, press_p or release_p fires same cycle. Counter never wraps.
- Drive: line[i] = pressed[i] ? 0 : Z. Never drives 1.
- Receive: line[i] passes through SYNC_STAGES flops (reset 1). remote_low[i] = (synced line == 0) AND NOT pressed[i] AND guard[i]==0.
- Guard: on release_p[i], guard[i] loads SYNC_STAGES+1 and counts down to 0; suppresses false detection from own still-propagating low. A new press during guard: guard keeps counting; own drive masks regardless.
- led[i] <= remote_low[i]. remote_p[i] = remote_low[i] AND NOT previous remote_low[i], registered with led.
- Channels fully independent; simultaneous events on different channels are all honoured in the same cycle.
- Reset mid-debounce or mid-stretch: state discarded, line released immediately (asynchronous).

## Timing
- btn step at cycle 0 (held): pressed, press_p and line low at cycle SYNC_STAGES+DEB_CYCLES.
- Bounce: any glitch back to old level before DEB_CYCLES consecutive samples restarts the count; no output change.
- Remote pull-low at cycle 0 (own idle, guard 0): led and remote_p at cycle SYNC_STAGES+1; led falls SYNC_STAGES+1 cycles after line returns high (non-stretch).
- Own release: line Z same cycle as release_p; led stays 0 through guard.

## Configuration
- OD_STRETCH_EN defined: per-channel stretch counter, width $clog2(STRETCH_CYCLES+1); reloaded to STRETCH_CYCLES every cycle remote_low=1; led = remote_low OR counter≠0; counter decrements to 0. remote_p unaffected (still raw start of detection).
- Undefined: no stretch counter; led follows remote_low with one register delay.

## Structure
- Package od_line_pkg: max CH constant (16), default DEB_CYCLES/SYNC_STAGES/STRETCH_CYCLES, line idle-level constant.
- Sub-module od_debounce (one instance per channel via generate): synchroniser, counter, pressed, press_p/release_p. Top holds tristate, guard, receive path, stretch.

## Test plan
Bench: CH=2, DEB_CYCLES=4, SYNC_STAGES=2, STRETCH_CYCLES=8.
- btn[0] held from cycle 0 → pressed[0], press_p[0] at cycle 6; line[0]=0; led[0]=0 throughout.
- btn[1] pulses high 3 cycles, low 1, high 3 → pressed[1] stays 0, no pulses, line[1] Z.
- External pull of line[1] low cycles 10–20 → led[1]=1 cycles 13–23, remote_p[1] single pulse at cycle 13 (with OD_STRETCH_EN: led[1] held through cycle 31).
- btn[0] released after press → release_p[0], line Z same cycle, led[0] never asserts during 3-cycle guard.
- Both channels pressed same cycle → press_p=2'b11 together; rst=0 mid-count → all outputs 0, lines Z immediately.
